if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. It owns the PC and issues one-outstanding fetch requests to instruction memory. It delivers `instruction`/`pc_out`/`valid_out` to decode. It absorbs decode's hazard freeze, branch-taken and jump redirects, and discards stale in-flight fetches on redirect.

## Interface
- `WORD_LEN`, 16: instruction/PC width.
- `RESET_PC`, 0: PC value loaded on reset.
- `NOP`, 0: instruction word presented when `valid_out`=0.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hazard_detected_in`  in  1  freeze: hold IF/ID and PC.
- `br_taken`  in  1  decode resolved a taken branch for the instruction in IF/ID.
- `br_offset`  in  WORD_LEN  sign-extended branch offset from decode.
- `jump_en`  in  1  decode holds a jump.
- `jump_addr`  in  12  jump target low bits.
- `imem_req`  out  1  fetch request, one-cycle pulse per request.
- `imem_addr`  out  WORD_LEN  word address of request, valid with `imem_req`.
- `imem_valid`  in  1  response strobe, ≥1 cycle after request.
- `imem_rdata`  in  WORD_LEN  fetched instruction, valid with `imem_valid`.
- `instruction`  out  WORD_LEN  IF/ID instruction to decode.
- `pc_out`  out  WORD_LEN  PC of `instruction`.
- `valid_out`  out  1  IF/ID holds a real instruction.

## Operation
- Word-addressed PC; sequential next PC = PC+1, mod 2^WORD_LEN.
- Redirect = `br_taken | jump_en`, qualified by `valid_out`. Target priority: jump over branch.
  - Jump target = {`pc_out`[15:12], `jump_addr`}.
  - Branch target = `pc_out` + 1 + `br_offset`, mod 2^WORD_LEN.
- Redirect has priority over freeze and over any same-cycle response.
- On redirect: PC <= target, IF/ID <= bubble (`valid_out`=0, `instruction`=NOP), skid buffer emptied, and any outstanding fetch marked for drop.
- One-entry skid buffer holds a response that arrives while frozen.
- FSM states:
  - IDLE (nothing outstanding): if no redirect, no freeze and skid empty, assert `imem_req` with `imem_addr`=PC and go WAIT.
  - WAIT (request outstanding, result wanted):
    - `imem_valid` and redirect -> discard data, IDLE.
    - `imem_valid` and freeze -> skid <= (`imem_rdata`, PC), PC <= PC+1, IDLE.
    - `imem_valid`, no freeze -> IF/ID <= (`imem_rdata`, PC, valid), PC <= PC+1. In the same cycle issue the next request at PC+1 and stay WAIT (back-to-back).
    - Redirect without `imem_valid` -> DROP.
  - DROP (request outstanding, result stale): no requests; on `imem_valid` discard data, go IDLE.
- IF/ID update rules:
  - Freeze with no redirect: IF/ID holds.
  - Not frozen, skid full: IF/ID <= skid, skid empties; next request issues from IDLE the following cycle.
  - Not frozen, no new data: IF/ID <= bubble, because decode consumed the previous instruction.
- `imem_valid` in IDLE is a protocol error: ignore it; no state change.
- Never more than one outstanding request; `imem_req` never asserted in DROP or while frozen.

## Timing
- Reset (async assert, sync-free release): PC=RESET_PC, state IDLE, skid empty, `valid_out`=0, `instruction`=NOP, `pc_out`=0.
- `imem_req`/`imem_addr` are combinational from state/PC/inputs. With `rst` low, `imem_req`=0.
- First request is in the first cycle after `rst` deasserts, at RESET_PC.
- 1-cycle memory: request cycle n, `imem_valid` n+1, `valid_out` high from n+2. Steady state one instruction per cycle.
- Redirect cycle r:
  - Memory response already returned: new request issues in r+1 (IDLE).
  - Request still outstanding: new request waits until the stale response drains, one cycle after the stale `imem_valid`.
  - First redirected instruction reaches IF/ID no earlier than r+3.
- PC wrap: 0xFFFF+1 = 0x0000; branch arithmetic wraps identically.
- Freeze deasserted with skid full: skid reaches IF/ID at that edge, then fetch resumes.

## Test plan
- Reset and stream: `rst` low 3 cycles, 1-cycle memory returning addr+0x1000 -> requests 0,1,2,… on consecutive cycles. `instruction` = 0x1000,0x1001,… with `pc_out` 0,1,…; first `valid_out` 2 cycles after reset release.
- Freeze with skid: freeze for 3 cycles while a response for PC=5 is in flight -> IF/ID holds PC=4 throughout, no `imem_req` while frozen. On release, PC=5 appears, then a request at 6.
- Branch: `valid_out`=1, `pc_out`=0x0010, `br_taken`=1, `br_offset`=0xFFFC -> bubble next cycle; next request at 0x000D.
- Jump with stale fetch: 3-cycle memory latency, `jump_en` with `pc_out`=0x2345, `jump_addr`=0x0ABC while a fetch is outstanding -> stale data never reaches IF/ID; next request at 0x2ABC only after the stale `imem_valid`.
- Simultaneous events: redirect and freeze in the same cycle as `imem_valid` -> data discarded, PC=target, skid empty, `valid_out`=0.
- Wrap and mid-run reset: PC=0xFFFF fetch -> next request 0x0000. Asserting `rst` while in WAIT -> outputs reset immediately, state IDLE, a late `imem_valid` is ignored.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps one fetch in flight,
// and drives the IF/ID register with a one-entry skid buffer.
module if_stage #(
  parameter int                  WORD_LEN = 16,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter logic [WORD_LEN-1:0] NOP      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_detected_in,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_offset,
  input  logic                jump_en,
  input  logic [11:0]         jump_addr,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_out,
  output logic                valid_out
);

  typedef struct packed {
    logic [WORD_LEN-1:0] ins;
    logic [WORD_LEN-1:0] pc;
    logic                vld;
  } if_id_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t state_q, state_d;

  logic [WORD_LEN-1:0] pc_q, pc_d;

  if_id_t if_id_q, if_id_d;
  if_id_t skid_q, skid_d;

  logic redirect;
  logic freeze;
  logic rsp;
  logic req_idle;
  logic req_b2b;

  logic [WORD_LEN-1:0] pc_inc;
  logic [WORD_LEN-1:0] br_tgt;
  logic [WORD_LEN-1:0] jmp_tgt;
  logic [WORD_LEN-1:0] tgt;

  if_id_t fetched;
  if_id_t bubble;
  if_id_t if_id_rst;

  assign freeze   = hazard_detected_in;
  assign rsp      = imem_valid;
  assign redirect = if_id_q.vld & (br_taken | jump_en);

  assign pc_inc  = pc_q + WORD_LEN'(1);
  assign br_tgt  = if_id_q.pc + WORD_LEN'(1) + br_offset;
  assign jmp_tgt = {if_id_q.pc[WORD_LEN-1:12], jump_addr};

  always_comb begin
    tgt = br_tgt;
    unique case (1'b1)
      jump_en:  tgt = jmp_tgt;
      default:  tgt = br_tgt;
    endcase
  end

  assign fetched = '{ins: imem_rdata, pc: pc_q, vld: 1'b1};
  // Bubbles keep the last PC so pc_out does not toggle needlessly.
  assign bubble  = '{ins: NOP, pc: if_id_q.pc, vld: 1'b0};

  assign if_id_rst = '{ins: NOP, pc: '0, vld: 1'b0};

  assign req_idle = (state_q == IDLE) & ~redirect
                  & ~freeze & ~skid_q.vld;
  assign req_b2b  = (state_q == WAIT) & rsp
                  & ~redirect & ~freeze;

  assign imem_req  = rst & (req_idle | req_b2b);
  assign imem_addr = req_b2b ? pc_inc : pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_id_d = if_id_q;
    skid_d  = skid_q;
    if (redirect) begin
      pc_d       = tgt;
      if_id_d    = bubble;
      skid_d.vld = 1'b0;
      unique case (state_q)
        WAIT:    state_d = rsp ? IDLE : DROP;
        DROP:    state_d = rsp ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          // Stray responses here are ignored.
          if (!freeze) begin
            if (skid_q.vld) begin
              if_id_d    = skid_q;
              skid_d.vld = 1'b0;
            end else begin
              if_id_d = bubble;
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (rsp && freeze) begin
            skid_d  = fetched;
            pc_d    = pc_inc;
            state_d = IDLE;
          end else if (rsp) begin
            if_id_d = fetched;
            pc_d    = pc_inc;
          end else if (!freeze) begin
            if_id_d = bubble;
          end
        end
        DROP: begin
          if (rsp) state_d = IDLE;
          if (!freeze) if_id_d = bubble;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      if_id_q <= if_id_rst;
      skid_q  <= if_id_rst;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      skid_q  <= skid_d;
    end
  end

  assign instruction = if_id_q.ins;
  assign pc_out      = if_id_q.pc;
  assign valid_out   = if_id_q.vld;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model with queued responses,
// request and IF/ID scoreboards, directed redirect/freeze cases.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hazard_detected_in = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_offset = '0;
  logic        jump_en = 1'b0;
  logic [11:0] jump_addr = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic        valid_out;

  if_stage dut (
    .clk                (clk),
    .rst                (rst),
    .hazard_detected_in (hazard_detected_in),
    .br_taken           (br_taken),
    .br_offset          (br_offset),
    .jump_en            (jump_en),
    .jump_addr          (jump_addr),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_valid         (imem_valid),
    .imem_rdata         (imem_rdata),
    .instruction        (instruction),
    .pc_out             (pc_out),
    .valid_out          (valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    int          cnt;
  } mreq_t;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pc;
  } dlv_t;

  mreq_t       mq[$];
  logic [15:0] rq[$];
  dlv_t        dq[$];
  int          lat = 1;

  always @(negedge clk)
    if (rst && imem_req) mq.push_back('{imem_addr, lat});

  always @(posedge clk) begin
    #1;
    imem_valid = 1'b0;
    imem_rdata = '0;
    foreach (mq[i]) mq[i].cnt--;
    if (mq.size() > 0 && mq[0].cnt <= 0) begin
      imem_valid = 1'b1;
      imem_rdata = mq[0].addr + 16'h1000;
      void'(mq.pop_front());
    end
  end

  logic        prev_hz = 1'b0;
  logic        prev_rd = 1'b0;
  logic        last_vo = 1'b0;
  logic [15:0] last_pc = '0;
  logic [15:0] last_ins = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hz = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (imem_req) begin
        if (hazard_detected_in) chk("req_frz", imem_req, 0);
        if (rq.size() == 0) chk("req_extra", imem_req, 0);
        else chk("req_addr", imem_addr, rq.pop_front());
      end
      if (prev_hz && !prev_rd) begin
        chk("hold_vo", valid_out, last_vo);
        chk("hold_pc", pc_out, last_pc);
        chk("hold_ins", instruction, last_ins);
      end else if (valid_out) begin
        if (dq.size() == 0) chk("vo_extra", valid_out, 0);
        else begin
          dlv_t e;
          e = dq.pop_front();
          chk("ins", instruction, e.ins);
          chk("pc", pc_out, e.pc);
        end
      end else begin
        chk("nop", instruction, 0);
      end
      prev_hz  = hazard_detected_in;
      prev_rd  = valid_out & (br_taken | jump_en);
      last_vo  = valid_out;
      last_pc  = pc_out;
      last_ins = instruction;
    end
  end

  task automatic exp_req(input logic [15:0] a);
    rq.push_back(a);
  endtask

  task automatic exp_dlv(input logic [15:0] p);
    dlv_t e;
    e.ins = p + 16'h1000;
    e.pc  = p;
    dq.push_back(e);
  endtask

  task automatic end_phase();
    chk("left_req", rq.size(), 0);
    chk("left_dlv", dq.size(), 0);
  endtask

  task automatic start(input int l);
    rst = 1'b0;
    hazard_detected_in = 1'b0;
    br_taken = 1'b0;
    br_offset = '0;
    jump_en = 1'b0;
    jump_addr = '0;
    mq.delete();
    rq.delete();
    dq.delete();
    lat = l;
    repeat (3) begin
      @(negedge clk);
      chk("rst_vo", valid_out, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_ins", instruction, 0);
      chk("rst_req", imem_req, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset and steady stream.
    start(1);
    for (int i = 0; i <= 9; i++) exp_req(16'(i));
    for (int i = 0; i <= 7; i++) exp_dlv(16'(i));
    rst = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 0) chk("first_req", imem_req, 1);
      if (c <= 2) chk("first_vo", valid_out, (c == 2) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    end_phase();

    // Freeze while PC=5 response is in flight.
    start(1);
    for (int i = 0; i <= 8; i++) exp_req(16'(i));
    for (int i = 0; i <= 6; i++) exp_dlv(16'(i));
    rst = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      hazard_detected_in = (c >= 6 && c <= 8);
      @(negedge clk);
      if (c == 8) chk("frz_pc", pc_out, 16'h4);
      if (c == 9) chk("frz_noreq", imem_req, 0);
      if (c == 10) begin
        chk("skid_pc", pc_out, 16'h5);
        chk("skid_vo", valid_out, 1);
        chk("resume_addr", imem_addr, 16'h6);
      end
      @(posedge clk);
      #1;
    end
    end_phase();

    // Taken branch with negative offset.
    start(1);
    for (int i = 0; i <= 17; i++) exp_req(16'(i));
    for (int i = 13; i <= 16; i++) exp_req(16'(i));
    for (int i = 0; i <= 16; i++) exp_dlv(16'(i));
    exp_dlv(16'hD);
    exp_dlv(16'hE);
    rst = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      br_taken  = (c == 18);
      br_offset = (c == 18) ? 16'hFFFC : 16'h0;
      @(negedge clk);
      if (c == 18) chk("br_pc", pc_out, 16'h10);
      if (c == 19) begin
        chk("br_bubble", valid_out, 0);
        chk("br_addr", imem_addr, 16'hD);
      end
      @(posedge clk);
      #1;
    end
    end_phase();

    // Branch and jump while a 3-cycle fetch is outstanding.
    start(3);
    exp_req(16'h0);
    exp_req(16'h1);
    exp_req(16'h2345);
    exp_req(16'h2346);
    exp_req(16'h2ABC);
    exp_req(16'h2ABD);
    exp_dlv(16'h0);
    exp_dlv(16'h2345);
    exp_dlv(16'h2ABC);
    rst = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      br_taken  = (c == 4) || (c == 11);
      br_offset = (c == 4) ? 16'h2344 : 16'h0;
      jump_en   = (c == 11);
      jump_addr = (c == 11) ? 12'hABC : 12'h0;
      @(negedge clk);
      if (c == 5) chk("drop_vo", valid_out, 0);
      if (c == 11) chk("jmp_pc", pc_out, 16'h2345);
      if (c == 12 || c == 13) chk("drop_noreq", imem_req, 0);
      if (c == 14) begin
        chk("jmp_req", imem_req, 1);
        chk("jmp_addr", imem_addr, 16'h2ABC);
      end
      @(posedge clk);
      #1;
    end
    end_phase();

    // Redirect, freeze and response in one cycle.
    start(1);
    for (int i = 0; i <= 4; i++) exp_req(16'(i));
    exp_req(16'h104);
    exp_req(16'h105);
    exp_req(16'h106);
    for (int i = 0; i <= 3; i++) exp_dlv(16'(i));
    exp_dlv(16'h104);
    rst = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      br_taken           = (c == 5);
      br_offset          = (c == 5) ? 16'h0100 : 16'h0;
      hazard_detected_in = (c == 5);
      @(negedge clk);
      if (c == 6) begin
        chk("sim_vo", valid_out, 0);
        chk("sim_req", imem_req, 1);
        chk("sim_addr", imem_addr, 16'h104);
      end
      @(posedge clk);
      #1;
    end
    end_phase();

    // PC wrap, branch wrap, mid-run reset with a late response.
    start(1);
    exp_req(16'h0);
    exp_req(16'h1);
    exp_req(16'hFFFE);
    exp_req(16'hFFFF);
    exp_req(16'h0);
    exp_req(16'h3);
    exp_req(16'h4);
    exp_req(16'h0);
    exp_req(16'h1);
    exp_dlv(16'h0);
    exp_dlv(16'hFFFE);
    exp_dlv(16'hFFFF);
    exp_dlv(16'h3);
    exp_dlv(16'h0);
    rst = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      if (c == 7) lat = 3;
      if (c == 12) rst = 1'b1;
      br_taken  = (c == 2) || (c == 6);
      br_offset = (c == 2) ? 16'hFFFD : (c == 6) ? 16'h0003 : 16'h0;
      hazard_detected_in = (c >= 12 && c <= 14);
      @(negedge clk);
      if (c == 5) chk("wrap_addr", imem_addr, 16'h0);
      if (c == 6) chk("wrap_pc", pc_out, 16'hFFFF);
      if (c == 7) chk("brwrap_addr", imem_addr, 16'h3);
      if (c == 11) begin
        #2;
        rst = 1'b0;
        #1;
        chk("mid_vo", valid_out, 0);
        chk("mid_pc", pc_out, 0);
        chk("mid_ins", instruction, 0);
        chk("mid_req", imem_req, 0);
      end
      if (c == 13) begin
        chk("late_vo", valid_out, 0);
        chk("late_req", imem_req, 0);
      end
      if (c == 15) begin
        chk("post_req", imem_req, 1);
        chk("post_addr", imem_addr, 16'h0);
      end
      @(posedge clk);
      #1;
    end
    end_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
